// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_pkg
// Purpose  : Shared definitions for the instruction-decode stage: instruction
//            field offsets, opcode / decoded-opcode encodings, decode helper
//            functions and the control part of the decoded bundle.
// Revision : 1.0 - initial release
// ============================================================================
package id_pkg;

  // Fixed field widths
  localparam int W_OPC  = 6;
  localparam int W_DOPC = 3;
  localparam int W_CC   = 2;

  // Field positions, counted down from the instruction MSB so the layout
  // follows WORD: opcode occupies the top W_OPC bits, immf sits directly
  // below it, then rd, then rs. The immediate is always at the LSBs.
  localparam int OPC_OFS  = 0;
  localparam int IMMF_OFS = W_OPC;
  localparam int RD_OFS   = W_OPC + 1;

  // Opcode encodings
  localparam logic [W_OPC-1:0] OPC_ADD = 6'h00;
  localparam logic [W_OPC-1:0] OPC_SUB = 6'h01;
  localparam logic [W_OPC-1:0] OPC_AND = 6'h02;
  localparam logic [W_OPC-1:0] OPC_OR  = 6'h03;
  localparam logic [W_OPC-1:0] OPC_XOR = 6'h04;
  localparam logic [W_OPC-1:0] OPC_SHL = 6'h05;
  localparam logic [W_OPC-1:0] OPC_SHR = 6'h06;
  localparam logic [W_OPC-1:0] OPC_LD  = 6'h07;
  localparam logic [W_OPC-1:0] OPC_ST  = 6'h08;
  localparam logic [W_OPC-1:0] OPC_BR  = 6'h09;

  // Decoded operation class handed to EX
  typedef enum logic [W_DOPC-1:0] {
    DOPC_ARITH  = 3'd0,
    DOPC_LOGIC  = 3'd1,
    DOPC_SHIFT  = 3'd2,
    DOPC_LOAD   = 3'd3,
    DOPC_STORE  = 3'd4,
    DOPC_BRANCH = 3'd5,
    DOPC_NOP    = 3'd6
  } dopc_e;

  // Width-independent control portion of a queued bundle
  typedef struct packed {
    dopc_e             dopc;
    logic [W_OPC-1:0]  opc;
    logic [W_CC-1:0]   cc;
    logic              wb;
  } ctl_t;

  function automatic dopc_e decode_ope(input logic [W_OPC-1:0] opc);
    dopc_e d;
    case (opc)
      OPC_ADD, OPC_SUB:          d = DOPC_ARITH;
      OPC_AND, OPC_OR, OPC_XOR:  d = DOPC_LOGIC;
      OPC_SHL, OPC_SHR:          d = DOPC_SHIFT;
      OPC_LD:                    d = DOPC_LOAD;
      OPC_ST:                    d = DOPC_STORE;
      OPC_BR:                    d = DOPC_BRANCH;
      default:                   d = DOPC_NOP;
    endcase
    return d;
  endfunction

  // Only operations that produce a register result reserve rd.
  function automatic logic wb_required(input logic [W_OPC-1:0] opc);
    dopc_e d;
    d = decode_ope(opc);
    return (d == DOPC_ARITH) || (d == DOPC_LOGIC) ||
           (d == DOPC_SHIFT) || (d == DOPC_LOAD);
  endfunction

  // Extends a w_imm-bit immediate (right-aligned in imm) to 64 bits; the
  // caller keeps the low WORD bits. Logic and shift ops zero-extend so that
  // masks like 0xFFFF stay masks; everything else sign-extends.
  function automatic logic [63:0] expand_imm(input logic [W_OPC-1:0] opc,
                                             input logic [63:0]      imm,
                                             input logic [6:0]       w_imm);
    logic        zext;
    logic        sign;
    logic [63:0] res;
    zext = (decode_ope(opc) == DOPC_LOGIC) || (decode_ope(opc) == DOPC_SHIFT);
    sign = imm[6'(w_imm - 7'd1)];
    for (int i = 0; i < 64; i++) begin
      res[i] = (7'(i) < w_imm) ? imm[i] : (~zext & sign);
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : id_fifo
// Purpose  : DEPTH-entry registered queue for decoded bundles, with flush.
// Ports    : clk, rst (async, active-low)
//            push_i/din_i  - write request and data (ignored when full
//                            unless a pop happens in the same cycle)
//            pop_i         - remove head entry (ignored when empty)
//            flush_i       - empty the queue; overrides push and pop
//            dout_o        - head entry, full_o / empty_o status
// Revision : 1.0 - initial release
// ============================================================================
module id_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push_w, do_pop_w;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop_w  = pop_i & ~empty_o & ~flush_i;
  assign do_push_w = push_i & (~full_o | do_pop_w) & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push_w) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop_w)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({do_push_w, do_pop_w})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is cleared on reset so the bundle outputs read zero afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push_w) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/idecode_buf.sv
`default_nettype none
// ============================================================================
// Module   : idecode_buf
// Purpose  : Instruction-decode stage between IF and EX. Decodes one
//            instruction per cycle, reads operands, interlocks on register
//            reservations and queues decoded bundles towards EX.
// Ports    : clk, rst (async, active-low)
//            IF side  : v_i, rdy_o, inst_i, origaddr_i, flush_i
//            RF side  : rd/rs_name_o, rd/rs_data_i, rd/rs_reserved_i,
//                       rd_reserve_o
//            EX side  : v_o, stall_i, src_o, dest_o, dopc_o, opc_o,
//                       origaddr_o, cc_o, wb_o, wb_rd_name_o
//            Status   : hazard_cnt_o (saturating interlock-stall count)
// Revision : 1.0 - initial release
// ============================================================================
module idecode_buf
  import id_pkg::*;
#(
  parameter int WORD  = 32,
  parameter int ADDR  = 32,
  parameter int W_RD  = 3,
  parameter int W_RS  = 3,
  parameter int W_IMM = 16,
  parameter int DEPTH = 2,
  parameter int W_CNT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  output logic              rdy_o,
  input  logic [WORD-1:0]   inst_i,
  input  logic [ADDR-1:0]   origaddr_i,
  input  logic              flush_i,
  output logic [W_RD-1:0]   rd_name_o,
  output logic [W_RS-1:0]   rs_name_o,
  input  logic [WORD-1:0]   rd_data_i,
  input  logic [WORD-1:0]   rs_data_i,
  input  logic              rd_reserved_i,
  input  logic              rs_reserved_i,
  output logic              rd_reserve_o,
  output logic              v_o,
  input  logic              stall_i,
  output logic [WORD-1:0]   src_o,
  output logic [WORD-1:0]   dest_o,
  output logic [W_DOPC-1:0] dopc_o,
  output logic [W_OPC-1:0]  opc_o,
  output logic [ADDR-1:0]   origaddr_o,
  output logic [W_CC-1:0]   cc_o,
  output logic              wb_o,
  output logic [W_RD-1:0]   wb_rd_name_o,
  output logic [W_CNT-1:0]  hazard_cnt_o
);

  typedef struct packed {
    logic [WORD-1:0] src;
    logic [WORD-1:0] dest;
    ctl_t            ctl;
    logic [ADDR-1:0] addr;
    logic [W_RD-1:0] rd;
  } bundle_t;

  logic [W_OPC-1:0] opc_w;
  logic             immf_w;
  logic [W_IMM-1:0] imm_w;
  logic [63:0]      imm_ext_w;
  logic             hazard_w;
  logic             accept_w;
  logic             full_w, empty_w, pop_w;
  bundle_t          push_w, head_w;
  logic [W_CNT-1:0] hazard_cnt_q, hazard_cnt_d;

  // Field extraction; the RF names are driven straight from the instruction.
  assign opc_w     = inst_i[WORD-1-OPC_OFS -: W_OPC];
  assign immf_w    = inst_i[WORD-1-IMMF_OFS];
  assign rd_name_o = inst_i[WORD-1-RD_OFS -: W_RD];
  assign rs_name_o = inst_i[WORD-1-RD_OFS-W_RD -: W_RS];
  assign imm_w     = inst_i[W_IMM-1:0];
  assign imm_ext_w = expand_imm(opc_w, 64'(imm_w), 7'(W_IMM));

  // rs is only a real source when no immediate replaces it.
  assign hazard_w = v_i & (rd_reserved_i | (~immf_w & rs_reserved_i));

  // rdy_o looks at full only, never at stall_i, so EX backpressure does not
  // reach IF combinationally. Held low while in reset.
  assign rdy_o        = rst & ~full_w & ~hazard_w & ~flush_i;
  assign accept_w     = v_i & rdy_o;
  assign rd_reserve_o = accept_w & wb_required(opc_w);

  always_comb begin
    push_w          = '0;
    push_w.src      = immf_w ? imm_ext_w[WORD-1:0] : rs_data_i;
    push_w.dest     = rd_data_i;
    push_w.ctl.dopc = decode_ope(opc_w);
    push_w.ctl.opc  = opc_w;
    push_w.ctl.cc   = rd_name_o[W_CC-1:0];
    push_w.ctl.wb   = wb_required(opc_w);
    push_w.addr     = origaddr_i;
    push_w.rd       = rd_name_o;
  end

  assign pop_w = ~empty_w & ~stall_i;

  id_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(bundle_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept_w),
    .din_i   (push_w),
    .pop_i   (pop_w),
    .flush_i (flush_i),
    .dout_o  (head_w),
    .full_o  (full_w),
    .empty_o (empty_w)
  );

  assign v_o          = ~empty_w;
  assign src_o        = head_w.src;
  assign dest_o       = head_w.dest;
  assign dopc_o       = head_w.ctl.dopc;
  assign opc_o        = head_w.ctl.opc;
  assign origaddr_o   = head_w.addr;
  assign cc_o         = head_w.ctl.cc;
  assign wb_o         = head_w.ctl.wb;
  assign wb_rd_name_o = head_w.rd;

  // Counts cycles an offered instruction was held by an interlock; a flushed
  // cycle is not a stall since the input is being discarded anyway.
  always_comb begin
    hazard_cnt_d = hazard_cnt_q;
    if (hazard_w && !flush_i && !(&hazard_cnt_q)) begin
      hazard_cnt_d = hazard_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hazard_cnt_q <= '0;
    else      hazard_cnt_q <= hazard_cnt_d;
  end

  assign hazard_cnt_o = hazard_cnt_q;

endmodule
`default_nettype wire
